// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, status flag positions, datapath width.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 2;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_LE = 3'b100
  } cond_e;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides taken from a condition code and the {V,N,Z} status.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] status_i,
  output logic       taken_o
);

  logic lt;
  assign lt = status_i[FLAG_N] ^ status_i[FLAG_V];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_AL: taken_o = 1'b1;
      COND_EQ: taken_o = status_i[FLAG_Z];
      COND_NE: taken_o = ~status_i[FLAG_Z];
      COND_LT: taken_o = lt;
      COND_LE: taken_o = lt | status_i[FLAG_Z];
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with architectural status, branch resolution and retire counter.
module ex_mem_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [2:0]        alu_flags,
  input  logic [2:0]        in_rd,
  input  logic              in_wr_reg,
  input  logic              in_wr_status,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [WORD_W-1:0] in_store_data,
  input  logic              in_is_branch,
  input  logic [2:0]        in_cond,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_result,
  output logic [2:0]        out_rd,
  output logic              out_wr_reg,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [WORD_W-1:0] out_store_data,
  output logic              branch_taken,
  output logic [2:0]        status,
  output logic [15:0]       retire_count
);

  logic              valid_q,  valid_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [2:0]        rd_q,     rd_d;
  logic              wr_reg_q, wr_reg_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [WORD_W-1:0] store_q,  store_d;
  logic              taken_q,  taken_d;
  logic [2:0]        status_q, status_d;
  logic [15:0]       count_q,  count_d;
  logic              cond_taken;

  // Branches resolve against the status held before this edge; no flag forwarding.
  cond_eval u_cond_eval (
    .cond_i   (in_cond),
    .status_i (status_q),
    .taken_o  (cond_taken)
  );

  assign in_ready = ~stall;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    wr_reg_d = wr_reg_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    store_d  = store_q;
    taken_d  = taken_q;
    status_d = status_q;
    count_d  = count_q;
    if (flush) begin
      valid_d  = 1'b0;
      wr_reg_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      taken_d  = 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        valid_d  = 1'b1;
        result_d = alu_out;
        rd_d     = in_rd;
        wr_reg_d = in_wr_reg;
        mem_rd_d = in_mem_rd;
        mem_wr_d = in_mem_wr;
        store_d  = in_store_data;
        taken_d  = in_is_branch & cond_taken;
        if (in_wr_status) status_d = alu_flags;
        count_d  = count_q + 16'd1;
      end else begin
        valid_d  = 1'b0;
        wr_reg_d = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        taken_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wr_reg_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      store_q  <= '0;
      taken_q  <= 1'b0;
      status_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_reg_q <= wr_reg_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      store_q  <= store_d;
      taken_q  <= taken_d;
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_rd         = rd_q;
  assign out_wr_reg     = wr_reg_q;
  assign out_mem_rd     = mem_rd_q;
  assign out_mem_wr     = mem_wr_q;
  assign out_store_data = store_q;
  assign branch_taken   = taken_q;
  assign status         = status_q;
  assign retire_count   = count_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed table, hand sequences, counter wrap, randomized model check.
module tb_ex_mem_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic [2:0]  in_rd;
  logic        in_wr_reg;
  logic        in_wr_status;
  logic        in_mem_rd;
  logic        in_mem_wr;
  logic [15:0] in_store_data;
  logic        in_is_branch;
  logic [2:0]  in_cond;
  logic        stall;
  logic        flush;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
  logic        out_wr_reg;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic [15:0] out_store_data;
  logic        branch_taken;
  logic [2:0]  status;
  logic [15:0] retire_count;

  int checks = 0;
  int errors = 0;

  ex_mem_reg dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .alu_out        (alu_out),
    .alu_flags      (alu_flags),
    .in_rd          (in_rd),
    .in_wr_reg      (in_wr_reg),
    .in_wr_status   (in_wr_status),
    .in_mem_rd      (in_mem_rd),
    .in_mem_wr      (in_mem_wr),
    .in_store_data  (in_store_data),
    .in_is_branch   (in_is_branch),
    .in_cond        (in_cond),
    .stall          (stall),
    .flush          (flush),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wr_reg     (out_wr_reg),
    .out_mem_rd     (out_mem_rd),
    .out_mem_wr     (out_mem_wr),
    .out_store_data (out_store_data),
    .branch_taken   (branch_taken),
    .status         (status),
    .retire_count   (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: the architectural view of the EX/MEM stage.
  logic        m_valid, m_wr, m_mrd, m_mwr, m_taken;
  logic [15:0] m_result, m_sd;
  logic [2:0]  m_rd, m_status;
  int          m_count;

  function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] s);
    logic z, n, v;
    z = s[0]; n = s[1]; v = s[2];
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_valid = 0; m_wr = 0; m_mrd = 0; m_mwr = 0; m_taken = 0;
      m_result = 0; m_sd = 0; m_rd = 0; m_status = 0; m_count = 0;
    end else if (flush) begin
      m_valid = 0; m_wr = 0; m_mrd = 0; m_mwr = 0; m_taken = 0;
    end else if (!stall) begin
      if (in_valid) begin
        m_valid  = 1;
        m_result = alu_out;
        m_rd     = in_rd;
        m_wr     = in_wr_reg;
        m_mrd    = in_mem_rd;
        m_mwr    = in_mem_wr;
        m_sd     = in_store_data;
        m_taken  = in_is_branch && ref_taken(in_cond, m_status);
        if (in_wr_status) m_status = alu_flags;
        m_count  = (m_count + 1) % 65536;
      end else begin
        m_valid = 0; m_wr = 0; m_mrd = 0; m_mwr = 0; m_taken = 0;
      end
    end
  endtask

  typedef struct {
    logic        v;
    logic        ws;
    logic [2:0]  fl;
    logic        br;
    logic [2:0]  cd;
    logic        fs;
    logic        ev;
    logic        et;
    logic [2:0]  es;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[13];

  initial begin
    reset = 1; in_valid = 1; alu_out = 16'h5555; alu_flags = 3'b111; in_rd = 3'd7;
    in_wr_reg = 1; in_wr_status = 1; in_mem_rd = 1; in_mem_wr = 1;
    in_store_data = 16'hAAAA; in_is_branch = 1; in_cond = 3'd0; stall = 0; flush = 0;

    // reset held for two edges while the EX stage presents a live instruction
    step(); step();
    chk("rst_valid",  out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd",     out_rd, 0);
    chk("rst_wr_reg", out_wr_reg, 0);
    chk("rst_mem_rd", out_mem_rd, 0);
    chk("rst_mem_wr", out_mem_wr, 0);
    chk("rst_sd",     out_store_data, 0);
    chk("rst_taken",  branch_taken, 0);
    chk("rst_status", status, 0);
    chk("rst_count",  retire_count, 0);

    //            v  ws fl      br cd      fs ev et es      ec
    tbl[0]  = '{1, 1, 3'b001, 0, 3'b000, 0, 1, 0, 3'b001, 16'd1};
    tbl[1]  = '{1, 0, 3'b000, 1, 3'b001, 0, 1, 1, 3'b001, 16'd2};
    tbl[2]  = '{1, 0, 3'b000, 1, 3'b010, 0, 1, 0, 3'b001, 16'd3};
    tbl[3]  = '{1, 1, 3'b010, 0, 3'b000, 0, 1, 0, 3'b010, 16'd4};
    tbl[4]  = '{1, 0, 3'b000, 1, 3'b011, 0, 1, 1, 3'b010, 16'd5};
    tbl[5]  = '{1, 0, 3'b000, 1, 3'b100, 0, 1, 1, 3'b010, 16'd6};
    tbl[6]  = '{1, 1, 3'b110, 0, 3'b000, 0, 1, 0, 3'b110, 16'd7};
    tbl[7]  = '{1, 0, 3'b000, 1, 3'b011, 0, 1, 0, 3'b110, 16'd8};
    tbl[8]  = '{1, 0, 3'b000, 1, 3'b100, 0, 1, 0, 3'b110, 16'd9};
    tbl[9]  = '{1, 0, 3'b000, 1, 3'b000, 0, 1, 1, 3'b110, 16'd10};
    tbl[10] = '{1, 0, 3'b000, 1, 3'b101, 0, 1, 0, 3'b110, 16'd11};
    tbl[11] = '{0, 0, 3'b000, 1, 3'b000, 0, 0, 0, 3'b110, 16'd11};
    tbl[12] = '{1, 1, 3'b001, 0, 3'b000, 1, 0, 0, 3'b110, 16'd11};

    reset = 0; in_wr_reg = 1; in_mem_rd = 0; in_mem_wr = 0; in_rd = 3'd1;
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v; in_wr_status = tbl[i].ws; alu_flags = tbl[i].fl;
      in_is_branch = tbl[i].br; in_cond = tbl[i].cd; flush = tbl[i].fs;
      alu_out = 16'hA000 + 16'(i);
      step();
      chk($sformatf("tbl%0d_valid", i),  out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_taken", i),  branch_taken, tbl[i].et);
      chk($sformatf("tbl%0d_status", i), status, tbl[i].es);
      chk($sformatf("tbl%0d_count", i),  retire_count, tbl[i].ec);
      if (tbl[i].ev) chk($sformatf("tbl%0d_result", i), out_result, 16'hA000 + 16'(i));
    end

    // stall: outputs and counter freeze while upstream changes its inputs
    flush = 0; in_valid = 1; in_wr_status = 0; in_is_branch = 0;
    alu_out = 16'h1234; in_rd = 3'd5;
    step();
    chk("ld_result", out_result, 16'h1234);
    chk("ld_rd",     out_rd, 5);
    chk("ld_count",  retire_count, 12);
    alu_out = 16'hBEEF; in_rd = 3'd2; stall = 1;
    #1;
    chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_result", i), out_result, 16'h1234);
      chk($sformatf("stall%0d_rd", i),     out_rd, 5);
      chk($sformatf("stall%0d_valid", i),  out_valid, 1);
      chk($sformatf("stall%0d_count", i),  retire_count, 12);
    end
    stall = 0;
    #1;
    chk("rel_ready", in_ready, 1);
    step();
    chk("rel_result", out_result, 16'hBEEF);
    chk("rel_rd",     out_rd, 2);
    chk("rel_count",  retire_count, 13);

    // flush alone, then flush with stall: status and counter untouched
    flush = 1; in_wr_status = 1; alu_flags = 3'b100; in_wr_reg = 1;
    step();
    chk("fl_valid",  out_valid, 0);
    chk("fl_wr_reg", out_wr_reg, 0);
    chk("fl_status", status, 3'b110);
    chk("fl_count",  retire_count, 13);
    stall = 1;
    step();
    chk("fls_valid",  out_valid, 0);
    chk("fls_wr_reg", out_wr_reg, 0);
    chk("fls_status", status, 3'b110);
    chk("fls_count",  retire_count, 13);

    // counter wrap
    reset = 1; flush = 0; stall = 0;
    step();
    reset = 0; in_valid = 1; in_wr_status = 0;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", retire_count, 16'hFFFF);
    step();
    chk("wrap_0000", retire_count, 16'h0000);

    // randomized run against the reference model
    reset = 1; flush = 0; stall = 0;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) < 2);
      in_valid      = ($urandom_range(0, 99) < 75);
      stall         = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 10);
      alu_out       = 16'($urandom);
      alu_flags     = 3'($urandom);
      in_rd         = 3'($urandom);
      in_wr_reg     = 1'($urandom);
      in_mem_rd     = 1'($urandom);
      in_mem_wr     = 1'($urandom);
      in_store_data = 16'($urandom);
      in_cond       = 3'($urandom);
      in_is_branch  = ($urandom_range(0, 99) < 40);
      in_wr_status  = in_is_branch ? 1'b0 : ($urandom_range(0, 99) < 40);
      #1;
      chk("rnd_ready", in_ready, !stall);
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_valid",  out_valid, m_valid);
      chk("rnd_wr_reg", out_wr_reg, m_wr);
      chk("rnd_mem_rd", out_mem_rd, m_mrd);
      chk("rnd_mem_wr", out_mem_wr, m_mwr);
      chk("rnd_taken",  branch_taken, m_taken);
      chk("rnd_status", status, m_status);
      chk("rnd_count",  retire_count, 32'(m_count));
      if (m_valid) begin
        chk("rnd_result", out_result, m_result);
        chk("rnd_rd",     out_rd, m_rd);
        chk("rnd_sd",     out_store_data, m_sd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
